// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcodes, T-state encodings and
// control-word bit positions used by the sequencer and the datapath.
package cpu_pkg;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned STEP_W   = 3;
    localparam int unsigned CW_W     = 15;

    localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_LDA = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_STA = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_LDI = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_JMP = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_JC  = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

    localparam logic [STEP_W-1:0] T0 = 3'd0;
    localparam logic [STEP_W-1:0] T1 = 3'd1;
    localparam logic [STEP_W-1:0] T2 = 3'd2;
    localparam logic [STEP_W-1:0] T3 = 3'd3;
    localparam logic [STEP_W-1:0] T4 = 3'd4;

    localparam int unsigned CW_PC_EN    = 0;
    localparam int unsigned CW_PC_OE    = 1;
    localparam int unsigned CW_PC_LD    = 2;
    localparam int unsigned CW_MAR_LD   = 3;
    localparam int unsigned CW_RAM_OE   = 4;
    localparam int unsigned CW_RAM_WE   = 5;
    localparam int unsigned CW_IR_LD    = 6;
    localparam int unsigned CW_IR_OE    = 7;
    localparam int unsigned CW_A_LD     = 8;
    localparam int unsigned CW_A_OE     = 9;
    localparam int unsigned CW_B_LD     = 10;
    localparam int unsigned CW_ALU_OE   = 11;
    localparam int unsigned CW_ALU_SUB  = 12;
    localparam int unsigned CW_FLAGS_LD = 13;
    localparam int unsigned CW_OUT_LD   = 14;

endpackage

// File: rtl/control_sequencer_step_counter.sv
// T-state counter: advances while run and not held, wraps to T0 on the
// opcode's last step and never passes T4.
module step_counter
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              clr,
    input  logic              hold,
    output logic [STEP_W-1:0] step
);

    logic [STEP_W-1:0] r_step;
    logic [STEP_W-1:0] w_step_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_step <= T0;
        end else begin
            r_step <= w_step_nxt;
        end
    end

    // Wrap on last step; the T4 bound protects against a bad clr decode.
    always_comb begin
        w_step_nxt = r_step;
        if (run && !hold) begin
            if (clr || (r_step >= T4)) begin
                w_step_nxt = T0;
            end else begin
                w_step_nxt = r_step + STEP_W'(1);
            end
        end
    end

    always_comb begin
        step = r_step;
    end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control unit: decodes (T-state, opcode, flags) into the
// per-cycle control word and tracks the halted state.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                flag_c,
    input  logic                flag_z,
    output logic                pc_en,
    output logic                pc_oe,
    output logic                pc_ld,
    output logic                mar_ld,
    output logic                ram_oe,
    output logic                ram_we,
    output logic                ir_ld,
    output logic                ir_oe,
    output logic                a_ld,
    output logic                a_oe,
    output logic                b_ld,
    output logic                alu_oe,
    output logic                alu_sub,
    output logic                flags_ld,
    output logic                out_ld,
    output logic                halted,
    output logic [STEP_W-1:0]   step
);

    logic              r_halted;
    logic [STEP_W-1:0] w_step;
    logic              w_active;
    logic              w_last;
    logic [CW_W-1:0]   w_cw;

    assign w_active = run & ~r_halted;

    step_counter u_step_counter (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .clr  (w_last),
        .hold (r_halted),
        .step (w_step)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_halted <= 1'b0;
        end else if (w_active && (w_step == T2) && (opcode == OP_HLT)) begin
            r_halted <= 1'b1;
        end
    end

    // Microcode decode; fetch is common, execute steps depend on opcode.
    always_comb begin
        w_cw   = '0;
        w_last = 1'b0;
        unique case (w_step)
            T0: begin
                w_cw[CW_PC_OE]  = 1'b1;
                w_cw[CW_MAR_LD] = 1'b1;
            end
            T1: begin
                w_cw[CW_RAM_OE] = 1'b1;
                w_cw[CW_IR_LD]  = 1'b1;
                w_cw[CW_PC_EN]  = 1'b1;
            end
            T2: begin
                w_last = 1'b1;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        w_cw[CW_IR_OE]  = 1'b1;
                        w_cw[CW_MAR_LD] = 1'b1;
                        w_last          = 1'b0;
                    end
                    OP_LDI: begin
                        w_cw[CW_IR_OE] = 1'b1;
                        w_cw[CW_A_LD]  = 1'b1;
                    end
                    OP_JMP: begin
                        w_cw[CW_IR_OE] = 1'b1;
                        w_cw[CW_PC_LD] = 1'b1;
                    end
                    OP_JC: begin
                        w_cw[CW_IR_OE] = 1'b1;
                        w_cw[CW_PC_LD] = flag_c;
                    end
                    OP_JZ: begin
                        w_cw[CW_IR_OE] = 1'b1;
                        w_cw[CW_PC_LD] = flag_z;
                    end
                    OP_OUT: begin
                        w_cw[CW_A_OE]   = 1'b1;
                        w_cw[CW_OUT_LD] = 1'b1;
                    end
                    default: ;
                endcase
            end
            T3: begin
                w_last = 1'b1;
                case (opcode)
                    OP_LDA: begin
                        w_cw[CW_RAM_OE] = 1'b1;
                        w_cw[CW_A_LD]   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        w_cw[CW_RAM_OE] = 1'b1;
                        w_cw[CW_B_LD]   = 1'b1;
                        w_last          = 1'b0;
                    end
                    OP_STA: begin
                        w_cw[CW_A_OE]   = 1'b1;
                        w_cw[CW_RAM_WE] = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                w_last = 1'b1;
                if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                    w_cw[CW_ALU_OE]   = 1'b1;
                    w_cw[CW_A_LD]     = 1'b1;
                    w_cw[CW_FLAGS_LD] = 1'b1;
                    w_cw[CW_ALU_SUB]  = (opcode == OP_SUB);
                end
            end
            default: w_last = 1'b1;
        endcase
    end

    // Outputs: control word gated off while frozen or halted.
    always_comb begin
        pc_en    = w_active & w_cw[CW_PC_EN];
        pc_oe    = w_active & w_cw[CW_PC_OE];
        pc_ld    = w_active & w_cw[CW_PC_LD];
        mar_ld   = w_active & w_cw[CW_MAR_LD];
        ram_oe   = w_active & w_cw[CW_RAM_OE];
        ram_we   = w_active & w_cw[CW_RAM_WE];
        ir_ld    = w_active & w_cw[CW_IR_LD];
        ir_oe    = w_active & w_cw[CW_IR_OE];
        a_ld     = w_active & w_cw[CW_A_LD];
        a_oe     = w_active & w_cw[CW_A_OE];
        b_ld     = w_active & w_cw[CW_B_LD];
        alu_oe   = w_active & w_cw[CW_ALU_OE];
        alu_sub  = w_active & w_cw[CW_ALU_SUB];
        flags_ld = w_active & w_cw[CW_FLAGS_LD];
        out_ld   = w_active & w_cw[CW_OUT_LD];
        halted   = r_halted;
        step     = w_step;
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch/execute words, conditional
// jumps, run freeze, halt, async reset and bus-enable exclusivity.
module tb_control_sequencer;

    localparam logic [14:0] M_PC_EN    = 15'h0001;
    localparam logic [14:0] M_PC_OE    = 15'h0002;
    localparam logic [14:0] M_PC_LD    = 15'h0004;
    localparam logic [14:0] M_MAR_LD   = 15'h0008;
    localparam logic [14:0] M_RAM_OE   = 15'h0010;
    localparam logic [14:0] M_RAM_WE   = 15'h0020;
    localparam logic [14:0] M_IR_LD    = 15'h0040;
    localparam logic [14:0] M_IR_OE    = 15'h0080;
    localparam logic [14:0] M_A_LD     = 15'h0100;
    localparam logic [14:0] M_A_OE     = 15'h0200;
    localparam logic [14:0] M_B_LD     = 15'h0400;
    localparam logic [14:0] M_ALU_OE   = 15'h0800;
    localparam logic [14:0] M_ALU_SUB  = 15'h1000;
    localparam logic [14:0] M_FLAGS_LD = 15'h2000;
    localparam logic [14:0] M_OUT_LD   = 15'h4000;
    localparam logic [14:0] W_FETCH0   = M_PC_OE | M_MAR_LD;
    localparam logic [14:0] W_FETCH1   = M_RAM_OE | M_IR_LD | M_PC_EN;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [3:0] opcode;
    logic       flag_c;
    logic       flag_z;
    logic pc_en, pc_oe, pc_ld, mar_ld, ram_oe, ram_we, ir_ld, ir_oe;
    logic a_ld, a_oe, b_ld, alu_oe, alu_sub, flags_ld, out_ld, halted;
    logic [2:0]  step;
    logic [14:0] cw;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .flag_c(flag_c), .flag_z(flag_z),
        .pc_en(pc_en), .pc_oe(pc_oe), .pc_ld(pc_ld), .mar_ld(mar_ld),
        .ram_oe(ram_oe), .ram_we(ram_we), .ir_ld(ir_ld), .ir_oe(ir_oe),
        .a_ld(a_ld), .a_oe(a_oe), .b_ld(b_ld), .alu_oe(alu_oe),
        .alu_sub(alu_sub), .flags_ld(flags_ld), .out_ld(out_ld),
        .halted(halted), .step(step)
    );

    assign cw = {out_ld, flags_ld, alu_sub, alu_oe, b_ld, a_oe, a_ld, ir_oe,
                 ir_ld, ram_we, ram_oe, mar_ld, pc_ld, pc_oe, pc_en};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-derived microcode table.
    function automatic logic [14:0] exp_word(input logic [3:0] op, input int s,
                                             input logic c, input logic z);
        logic [14:0] w;
        w = '0;
        case (s)
            0: w = W_FETCH0;
            1: w = W_FETCH1;
            2: case (op)
                4'h1, 4'h2, 4'h3, 4'h4: w = M_IR_OE | M_MAR_LD;
                4'h5: w = M_IR_OE | M_A_LD;
                4'h6: w = M_IR_OE | M_PC_LD;
                4'h7: w = M_IR_OE | (c ? M_PC_LD : 15'h0);
                4'h8: w = M_IR_OE | (z ? M_PC_LD : 15'h0);
                4'hE: w = M_A_OE | M_OUT_LD;
                default: w = '0;
            endcase
            3: case (op)
                4'h1: w = M_RAM_OE | M_A_LD;
                4'h2, 4'h3: w = M_RAM_OE | M_B_LD;
                4'h4: w = M_A_OE | M_RAM_WE;
                default: w = '0;
            endcase
            4: case (op)
                4'h2: w = M_ALU_OE | M_A_LD | M_FLAGS_LD;
                4'h3: w = M_ALU_OE | M_A_LD | M_FLAGS_LD | M_ALU_SUB;
                default: w = '0;
            endcase
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic int exp_len(input logic [3:0] op);
        case (op)
            4'h1, 4'h4: return 4;
            4'h2, 4'h3: return 5;
            default:    return 3;
        endcase
    endfunction

    // Bus-driver exclusivity and PC control sanity every cycle.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("bus_onehot", 32'($countones({pc_oe, ram_oe, ir_oe, a_oe, alu_oe})) <= 1, 1);
            chk("pc_en_ld", 32'(pc_en & pc_ld), 0);
        end
    end

    initial begin
        rst = 1'b0; run = 1'b1; opcode = 4'h5; flag_c = 1'b0; flag_z = 1'b0;
        #12;
        chk("rst_step", 32'(step), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_word", 32'(cw), 32'(W_FETCH0));
        rst = 1'b1;

        // LDI
        tick(); chk("ldi_t1_step", 32'(step), 1); chk("ldi_t1", 32'(cw), 32'(W_FETCH1));
        tick(); chk("ldi_t2_step", 32'(step), 2); chk("ldi_t2", 32'(cw), 32'(M_IR_OE | M_A_LD));
        tick(); chk("ldi_t0_step", 32'(step), 0); chk("ldi_t0", 32'(cw), 32'(W_FETCH0));

        // SUB
        opcode = 4'h3;
        tick(); chk("sub_t1_step", 32'(step), 1);
        tick(); chk("sub_t2", 32'(cw), 32'(M_IR_OE | M_MAR_LD));
        tick(); chk("sub_t3_step", 32'(step), 3); chk("sub_t3", 32'(cw), 32'(M_RAM_OE | M_B_LD));
        tick(); chk("sub_t4_step", 32'(step), 4);
        chk("sub_t4", 32'(cw), 32'(M_ALU_OE | M_A_LD | M_FLAGS_LD | M_ALU_SUB));
        tick(); chk("sub_t0_step", 32'(step), 0);

        // JC / JZ with each flag value; the other flag is set to show it is ignored
        opcode = 4'h7; flag_c = 1'b0; flag_z = 1'b1;
        tick(); tick(); chk("jc0_t2", 32'(cw), 32'(M_IR_OE));
        tick(); flag_c = 1'b1; flag_z = 1'b0;
        tick(); tick(); chk("jc1_t2", 32'(cw), 32'(M_IR_OE | M_PC_LD));
        tick(); opcode = 4'h8; flag_c = 1'b1; flag_z = 1'b0;
        tick(); tick(); chk("jz0_t2", 32'(cw), 32'(M_IR_OE));
        tick(); flag_c = 1'b0; flag_z = 1'b1;
        tick(); tick(); chk("jz1_t2", 32'(cw), 32'(M_IR_OE | M_PC_LD));
        tick(); chk("jz_t0_step", 32'(step), 0);

        // run=0 during T3 of ADD
        opcode = 4'h2;
        tick(); tick(); tick(); chk("add_t3", 32'(cw), 32'(M_RAM_OE | M_B_LD));
        run = 1'b0; #1;
        chk("frz_word", 32'(cw), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("frz_step", 32'(step), 3);
            chk("frz_word", 32'(cw), 0);
        end
        run = 1'b1; #1;
        chk("resume_t3", 32'(cw), 32'(M_RAM_OE | M_B_LD));
        tick(); chk("resume_t4_step", 32'(step), 4);
        chk("resume_t4", 32'(cw), 32'(M_ALU_OE | M_A_LD | M_FLAGS_LD));
        tick(); chk("resume_t0_step", 32'(step), 0);

        // Async reset in T3 of LDA
        opcode = 4'h1;
        tick(); tick(); tick(); chk("lda_t3", 32'(cw), 32'(M_RAM_OE | M_A_LD));
        #1 rst = 1'b0; #1;
        chk("async_rst_step", 32'(step), 0);
        chk("async_rst_word", 32'(cw), 32'(W_FETCH0));
        #2 rst = 1'b1;
        tick(); chk("post_rst_step", 32'(step), 1);
        tick(); tick(); tick(); chk("lda_done_step", 32'(step), 0);

        // Sweep every non-halting opcode against the table
        flag_c = 1'b1; flag_z = 1'b0;
        for (int op = 0; op < 15; op++) begin
            opcode = 4'(op);
            for (int s = 0; s < exp_len(4'(op)); s++) begin
                chk($sformatf("sweep_op%0d_step%0d", op, s), 32'(step), 32'(s));
                chk($sformatf("sweep_op%0d_word%0d", op, s), 32'(cw),
                    32'(exp_word(4'(op), s, flag_c, flag_z)));
                tick();
            end
            chk($sformatf("sweep_op%0d_wrap", op), 32'(step), 0);
        end

        // HLT
        opcode = 4'hF;
        tick(); tick();
        chk("hlt_t2_step", 32'(step), 2);
        chk("hlt_t2_word", 32'(cw), 0);
        chk("hlt_t2_halted", 32'(halted), 0);
        tick();
        chk("hlt_halted", 32'(halted), 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hlt_step", 32'(step), 0);
            chk("hlt_word", 32'(cw), 0);
            chk("hlt_hold", 32'(halted), 1);
        end
        #1 rst = 1'b0; #1 rst = 1'b1; #1;
        chk("unhalt", 32'(halted), 0);
        chk("unhalt_step", 32'(step), 0);
        chk("unhalt_word", 32'(cw), 32'(W_FETCH0));
        tick(); chk("unhalt_run", 32'(step), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
